// File: rtl/audio_sample_memory.sv
// rtl/audio_sample_memory.sv - sample RAM with tick-paced record and playback
//
// Purpose: executes record/playback requests from the recorder control FSM.
//   While StartRecord is high, SampleIn is written into an internal RAM once
//   per sample tick until the RAM is full. While StartPlay is high, the
//   recorded samples are read back once per tick until the last one.
//
// Ports:
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous active-high reset (RAM contents kept)
//   StartRecord    in   record request level
//   StartPlay      in   playback request level (wins over StartRecord)
//   SampleIn       in   sample captured on record ticks
//   SampleOut      out  last sample read, registered
//   SampleValid    out  one-cycle pulse when SampleOut updates
//   MemoryFull     out  RAM full, recording stopped
//   StopReading    out  playback reached end of recording
//   RecordedLength out  number of valid samples stored

module audio_sample_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int TICK_DIV   = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  StartRecord,
  input  logic                  StartPlay,
  input  logic [DATA_WIDTH-1:0] SampleIn,
  output logic [DATA_WIDTH-1:0] SampleOut,
  output logic                  SampleValid,
  output logic                  MemoryFull,
  output logic                  StopReading,
  output logic [ADDR_WIDTH:0]   RecordedLength
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RECORD    = 3'd1;
  localparam logic [2:0] FULL      = 3'd2;
  localparam logic [2:0] PLAY      = 3'd3;
  localparam logic [2:0] STATE_END = 3'd4;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [2:0]            state;
  logic [2:0]            nextState;
  logic [CNT_W-1:0]      tickCount;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic                  tick;
  logic                  writeEn;
  logic                  readEn;
  logic                  startRecording;
  logic                  startPlaying;
  logic                  lastRead;

  assign tick     = ((state == RECORD) || (state == PLAY)) &&
                    (tickCount == CNT_W'(TICK_DIV - 1));
  assign lastRead = ({1'b0, rdAddr} == (RecordedLength - (ADDR_WIDTH + 1)'(1)));

  always_comb begin
    nextState      = state;
    writeEn        = 1'b0;
    readEn         = 1'b0;
    startRecording = 1'b0;
    startPlaying   = 1'b0;
    case (state)
      IDLE: begin
        if (StartPlay) begin
          if (RecordedLength != '0) begin
            nextState    = PLAY;
            startPlaying = 1'b1;
          end else begin
            nextState = STATE_END;
          end
        end else if (StartRecord) begin
          nextState      = RECORD;
          startRecording = 1'b1;
        end
      end
      RECORD: begin
        // A dropped request wins over a coincident tick: no write happens.
        if (!StartRecord) begin
          nextState = IDLE;
        end else if (tick) begin
          writeEn = 1'b1;
          if (wrAddr == {ADDR_WIDTH{1'b1}}) nextState = FULL;
        end
      end
      FULL: begin
        if (!StartRecord) nextState = IDLE;
      end
      PLAY: begin
        if (!StartPlay) begin
          nextState = IDLE;
        end else if (tick) begin
          readEn = 1'b1;
          if (lastRead) nextState = STATE_END;
        end
      end
      STATE_END: begin
        if (!StartPlay) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // RAM has no reset so recordings survive a Reset pulse.
  always_ff @(posedge Clock) begin
    if (writeEn) mem[wrAddr] <= SampleIn;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      tickCount      <= '0;
      wrAddr         <= '0;
      rdAddr         <= '0;
      RecordedLength <= '0;
      SampleOut      <= '0;
      SampleValid    <= 1'b0;
      MemoryFull     <= 1'b0;
      StopReading    <= 1'b0;
    end else begin
      state       <= nextState;
      MemoryFull  <= (nextState == FULL);
      StopReading <= (nextState == STATE_END);

      // Counter only runs while staying in an active state; entering or
      // leaving RECORD/PLAY restarts it from zero.
      if (((state == RECORD) || (state == PLAY)) && (nextState == state))
        tickCount <= tick ? '0 : tickCount + CNT_W'(1);
      else
        tickCount <= '0;

      if (startRecording) begin
        wrAddr         <= '0;
        RecordedLength <= '0;
      end else if (writeEn) begin
        wrAddr         <= wrAddr + ADDR_WIDTH'(1);
        RecordedLength <= RecordedLength + (ADDR_WIDTH + 1)'(1);
      end

      if (startPlaying)
        rdAddr <= '0;
      else if (readEn)
        rdAddr <= rdAddr + ADDR_WIDTH'(1);

      SampleValid <= readEn;
      if (readEn) SampleOut <= mem[rdAddr];
    end
  end

endmodule

// File: tb/tb_audio_sample_memory.sv
// tb/tb_audio_sample_memory.sv - scoreboard bench for audio_sample_memory

module tb_audio_sample_memory;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TD = 4;
  localparam int DEPTH = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          StartRecord = 1'b0;
  logic          StartPlay = 1'b0;
  logic [DW-1:0] SampleIn = '0;
  logic [DW-1:0] SampleOut;
  logic          SampleValid;
  logic          MemoryFull;
  logic          StopReading;
  logic [AW:0]   RecordedLength;

  audio_sample_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TICK_DIV(TD)) dut (
    .Clock(Clock), .Reset(Reset), .StartRecord(StartRecord), .StartPlay(StartPlay),
    .SampleIn(SampleIn), .SampleOut(SampleOut), .SampleValid(SampleValid),
    .MemoryFull(MemoryFull), .StopReading(StopReading), .RecordedLength(RecordedLength)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sbQueue[$];
  logic [DW-1:0] modelMem [DEPTH];
  int            modelLen = 0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every SampleValid pulse must match the oldest predicted read,
  // both in data and in the edge at which it appears.
  always @(negedge Clock) begin
    if (!Reset && SampleValid) begin
      if (sbQueue.size() == 0) begin
        check("unexpected_valid", 32'(SampleOut), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        check("sample_data", 32'(SampleOut), 32'(e.data));
        check("sample_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Hold StartRecord for h edges starting from IDLE. Edge offset j (0 = entry
  // edge) is a tick when j is a positive multiple of TD; the RAM stops taking
  // samples once DEPTH have been written.
  task automatic record_session(input int h, input bit seqData);
    int w;
    w = 0;
    for (int j = 0; j < h; j++) begin
      StartRecord = 1'b1;
      SampleIn = DW'($urandom);
      if (j > 0 && (j % TD) == 0 && w < DEPTH) begin
        if (seqData) SampleIn = DW'(8'h11 + w);
        modelMem[w] = SampleIn;
        w++;
      end
      @(posedge Clock);
      @(negedge Clock);
      check("rec_full", 32'(MemoryFull), 32'(w == DEPTH));
      check("rec_len", 32'(RecordedLength), 32'(w));
      check("rec_stop", 32'(StopReading), 0);
    end
    StartRecord = 1'b0;
    modelLen = w;
    @(posedge Clock);
    @(negedge Clock);
    check("rec_idle_full", 32'(MemoryFull), 0);
    check("rec_final_len", 32'(RecordedLength), 32'(modelLen));
  endtask

  // Hold StartPlay for h edges; optionally hold StartRecord too.
  task automatic play_session(input int h, input bit both);
    int r;
    exp_t e;
    r = 0;
    for (int j = 0; j < h; j++) begin
      StartPlay = 1'b1;
      StartRecord = both;
      if (j > 0 && (j % TD) == 0 && r < modelLen) begin
        e.data = modelMem[r];
        e.cyc = cyc + 1;
        sbQueue.push_back(e);
        r++;
      end
      @(posedge Clock);
      @(negedge Clock);
      check("play_stop", 32'(StopReading), 32'(modelLen == 0 || r == modelLen));
      check("play_full", 32'(MemoryFull), 0);
      check("play_len", 32'(RecordedLength), 32'(modelLen));
    end
    StartPlay = 1'b0;
    StartRecord = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check("play_idle_stop", 32'(StopReading), 0);
    check("play_drained", 32'(sbQueue.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_out", 32'(SampleOut), 0);
    check("reset_valid", 32'(SampleValid), 0);
    check("reset_full", 32'(MemoryFull), 0);
    check("reset_stop", 32'(StopReading), 0);
    check("reset_len", 32'(RecordedLength), 0);
    Reset = 1'b0;
    @(negedge Clock);

    record_session(21, 1'b1);          // five samples 0x11..0x15
    check("partial_len", 32'(modelLen), 5);
    play_session(30, 1'b0);
    record_session(45, 1'b0);          // runs into FULL
    play_session(40, 1'b0);            // mem[0] must still hold the first sample
    record_session(12, 1'b0);          // request drops on the third tick edge
    check("abort_len", 32'(RecordedLength), 2);
    play_session(20, 1'b1);            // both requests: play wins

    for (int i = 0; i < 8; i++) begin
      record_session(int'($urandom_range(1, 40)), 1'b0);
      play_session(int'($urandom_range(1, 45)), 1'($urandom_range(0, 1)));
    end

    // A full play first so SampleOut is non-zero, then reset mid-record.
    record_session(13, 1'b0);
    play_session(16, 1'b0);
    StartRecord = 1'b1;
    repeat (6) @(negedge Clock);
    Reset = 1'b1;
    StartRecord = 1'b0;
    #1;
    check("async_out", 32'(SampleOut), 0);
    check("async_valid", 32'(SampleValid), 0);
    check("async_full", 32'(MemoryFull), 0);
    check("async_stop", 32'(StopReading), 0);
    check("async_len", 32'(RecordedLength), 0);
    modelLen = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    play_session(6, 1'b0);             // empty play: END immediately, no pulses

    repeat (4) @(negedge Clock);
    check("final_queue", 32'(sbQueue.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_sample_memory.md
# audio_sample_memory

Sample-storage responder for the audio recorder: it executes the record and playback requests issued by the record/play control FSM and reports completion back to it. While `StartRecord` is high it captures `SampleIn` into an internal RAM at a divided sample rate, raising `MemoryFull` when the RAM is exhausted. While `StartPlay` is high it streams the recorded samples out at the same rate, raising `StopReading` after the last recorded sample.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM depth is 2^ADDR_WIDTH samples.
- `DATA_WIDTH`, default 8: sample width.
- `TICK_DIV`, default 4: clock cycles per sample tick; minimum 1.

Ports:
- `Clock`  in  1  system clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `StartRecord`  in  1  record request level from the control FSM.
- `StartPlay`  in  1  playback request level from the control FSM.
- `SampleIn`  in  DATA_WIDTH  sample to record; sampled on record ticks.
- `SampleOut`  out  DATA_WIDTH  last sample read; registered.
- `SampleValid`  out  1  one-cycle pulse when `SampleOut` updates.
- `MemoryFull`  out  1  level; RAM is full and recording has stopped.
- `StopReading`  out  1  level; playback has reached the end of the recording.
- `RecordedLength`  out  ADDR_WIDTH+1  number of valid samples stored.

## Operation
- States: IDLE, RECORD, FULL, PLAY, END. The state register resets to IDLE.
- Tick counter:
  - Cleared on entry to RECORD or PLAY and held at 0 in all other states.
  - Counts 0..TICK_DIV-1. A tick occurs in the cycle where count == TICK_DIV-1; the counter then wraps to 0.
- IDLE:
  - If `StartPlay` is high and `RecordedLength` != 0: go to PLAY with RdAddr=0.
  - If `StartPlay` is high and `RecordedLength` == 0: go to END.
  - Else if `StartRecord` is high: go to RECORD with WrAddr=0 and `RecordedLength`=0.
  - `StartPlay` has priority when both requests are high.
- RECORD:
  - If `StartRecord` is low: go to IDLE with no write, even on a tick cycle. `RecordedLength` is retained.
  - Else on a tick: write mem[WrAddr]=`SampleIn`, then increment WrAddr and `RecordedLength`.
  - If the write is at address 2^ADDR_WIDTH-1: go to FULL, with `RecordedLength`=2^ADDR_WIDTH.
- FULL: `MemoryFull`=1. When `StartRecord` is low, go to IDLE.
- PLAY:
  - If `StartPlay` is low: go to IDLE. Any read already issued still produces its `SampleValid` in the next cycle.
  - Else on a tick: issue a synchronous read of mem[RdAddr], then increment RdAddr.
  - If RdAddr == `RecordedLength`-1: go to END after that read.
- END: `StopReading`=1. When `StartPlay` is low, go to IDLE.
- `MemoryFull` and `StopReading` are registered decodes of FULL and END. They are never high together.
- RAM contents are not cleared by `Reset`. Playback is meaningful only after a recording completed since reset, because `RecordedLength` resets to 0.
- RdAddr and WrAddr are ADDR_WIDTH bits wide. WrAddr wraps to 0 when it increments past the last address, at the same edge the FSM enters FULL. No further writes occur in FULL.

## Timing
- Reset values: `SampleOut`=0, `SampleValid`=0, `MemoryFull`=0, `StopReading`=0, `RecordedLength`=0.
- Request acceptance: a request seen high at edge N changes the state at edge N.
- First tick: TICK_DIV cycles after entering RECORD or PLAY. Subsequent ticks follow every TICK_DIV cycles.
- Read latency:
  - A tick at cycle t gives `SampleOut` = data and `SampleValid`=1 in cycle t+1.
  - The last sample's `SampleValid` coincides with the first cycle of END.
- Write: takes effect at the tick edge. `RecordedLength` reflects the write one cycle later.
- FULL and END hold until the corresponding request drops. IDLE is reached one edge after the drop.
- A new request is evaluated in IDLE on the cycle after that.

## Test plan
Parameters for all scenarios: ADDR_WIDTH=3, TICK_DIV=4.

- **Reset:** assert `Reset` mid-RECORD -> all outputs 0 immediately (asynchronous), state IDLE, `RecordedLength`=0.
- **Partial record then play:**
  - Stimulus: record 5 ticks with `SampleIn`=0x11..0x15, drop `StartRecord`, then hold `StartPlay`.
  - Required: `RecordedLength`=5; five `SampleValid` pulses 4 cycles apart carrying 0x11..0x15; `StopReading`=1 with the last pulse, held until `StartPlay` drops.
- **Full memory:**
  - Stimulus: hold `StartRecord` for more than 40 cycles.
  - Required: exactly 8 writes; `MemoryFull`=1 from the edge after the 8th tick; `RecordedLength`=8; mem[0] not overwritten.
- **Empty play:** `StartPlay` after reset -> `StopReading`=1 at the next edge, no `SampleValid` pulses.
- **Simultaneous requests:** `StartPlay` and `StartRecord` high together in IDLE -> enters PLAY, `RecordedLength` unchanged.
- **Abort on tick:**
  - Stimulus: drop `StartRecord` in a tick cycle after 2 writes.
  - Required: `RecordedLength`=2, no third write, state IDLE, `MemoryFull` stays 0.
